// File: rtl/counter_pkg.sv
// Shared types and constants for the bounded up/down counter.
package counter_pkg;

    typedef enum logic {
        MODE_WRAP = 1'b0,
        MODE_SAT  = 1'b1
    } cnt_mode_e;

    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

endpackage

// File: rtl/counter_next.sv
// Combinational next-count and boundary-event calculation.
// Ports:
//   count     current count
//   step      increment/decrement amount (0 = hold, no event)
//   dir       DIR_UP / DIR_DOWN
//   mode      MODE_WRAP / MODE_SAT
//   min_val   lower bound (inclusive)
//   max_val   upper bound (inclusive)
//   nxt_count proposed next count
//   evt       boundary event for this update
module counter_next
    import counter_pkg::*;
#(
    parameter int unsigned WIDTH = 4
) (
    input  logic [WIDTH-1:0] count,
    input  logic [WIDTH-1:0] step,
    input  logic             dir,
    input  cnt_mode_e        mode,
    input  logic [WIDTH-1:0] min_val,
    input  logic [WIDTH-1:0] max_val,
    output logic [WIDTH-1:0] nxt_count,
    output logic             evt
);

    localparam int unsigned EW = WIDTH + 1;

    logic [EW-1:0] sum;
    logic [EW-1:0] diff;

    // One extra bit catches both carry-out and borrow; bounds are checked
    // against the unclamped result so an out-of-range count is never silently fixed.
    always_comb begin
        sum       = EW'(count) + EW'(step);
        diff      = EW'(count) - EW'(step);
        nxt_count = count;
        evt       = 1'b0;
        if (step != '0) begin
            case (dir)
                DIR_UP: begin
                    if (sum <= EW'(max_val)) begin
                        nxt_count = sum[WIDTH-1:0];
                    end else begin
                        evt       = 1'b1;
                        nxt_count = (mode == MODE_SAT) ? max_val : min_val;
                    end
                end
                DIR_DOWN: begin
                    if (!diff[WIDTH] && (diff[WIDTH-1:0] >= min_val)) begin
                        nxt_count = diff[WIDTH-1:0];
                    end else begin
                        evt       = 1'b1;
                        nxt_count = (mode == MODE_SAT) ? min_val : max_val;
                    end
                end
            endcase
        end
    end

endmodule

// File: rtl/bounded_updown_counter.sv
// Bounded up/down counter with programmable step, wrap/saturate mode,
// clamped synchronous load, terminal-count pulse and sticky overflow.
// Ports:
//   clk, rst      clock and synchronous active-low reset
//   en, dir, ld   count enable, direction (1 = up), load strobe
//   ld_val, step  load value, step amount
//   min_val/max_val inclusive bounds; mode 0 = wrap, 1 = saturate
//   clr_ovf       clears sticky ovf (a same-cycle event wins)
//   count, tc, ovf registered count, event pulse, sticky event flag
//   at_max, at_min, cfg_err combinational status
module bounded_updown_counter
    import counter_pkg::*;
#(
    parameter int unsigned       WIDTH   = 4,
    parameter logic [WIDTH-1:0]  RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             dir,
    input  logic             ld,
    input  logic [WIDTH-1:0] ld_val,
    input  logic [WIDTH-1:0] step,
    input  logic [WIDTH-1:0] min_val,
    input  logic [WIDTH-1:0] max_val,
    input  logic             mode,
    input  logic             clr_ovf,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             ovf,
    output logic             at_max,
    output logic             at_min,
    output logic             cfg_err
);

    logic [WIDTH-1:0] step_count;
    logic             step_evt;
    logic [WIDTH-1:0] ld_clamped;
    logic [WIDTH-1:0] count_d;
    logic             tc_d;
    logic             ovf_d;

    assign cfg_err = (min_val > max_val);
    assign at_max  = (count == max_val);
    assign at_min  = (count == min_val);

    counter_next #(
        .WIDTH (WIDTH)
    ) u_next (
        .count     (count),
        .step      (step),
        .dir       (dir),
        .mode      (cnt_mode_e'(mode)),
        .min_val   (min_val),
        .max_val   (max_val),
        .nxt_count (step_count),
        .evt       (step_evt)
    );

    // Load value is forced into the current bounds.
    always_comb begin
        ld_clamped = ld_val;
        if (ld_val < min_val) begin
            ld_clamped = min_val;
        end else if (ld_val > max_val) begin
            ld_clamped = max_val;
        end
    end

    // Priority mux: bad bounds freeze everything, then load, then count.
    always_comb begin
        count_d = count;
        tc_d    = 1'b0;
        if (!cfg_err) begin
            if (ld) begin
                count_d = ld_clamped;
            end else if (en) begin
                count_d = step_count;
                tc_d    = step_evt;
            end
        end
        ovf_d = tc_d | (ovf & ~clr_ovf);
    end

    // State registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            count <= RST_VAL;
            tc    <= 1'b0;
            ovf   <= 1'b0;
        end else begin
            count <= count_d;
            tc    <= tc_d;
            ovf   <= ovf_d;
        end
    end

endmodule
